fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Control-side initiator for the program counter and its bus handshake.
- Generates the PC's enable, increment and load strobes, and the fetch-side strobes for the address register, memory and instruction register.
- Captures the fetched instruction word from the shared 16-bit bus and hands control to the execute phase.
- Sits between the PC/memory datapath and the microcode/execute logic.

Parameters:
- WIDTH, 16, bus and instruction register width.
- MAX_T, 8, total T-states per instruction, fetch included; execute is forcibly ended at tstate MAX_T-1.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset_bar  input  1  asynchronous active-low reset.
- bus  input  WIDTH  shared data bus, read only by this block.
- mem_ready  input  1  memory has valid data on bus this cycle.
- exec_done  input  1  execute logic finished current instruction.
- jump  input  1  during execute: load PC from bus at next posedge.
- halt  input  1  stop at next instruction boundary.
- pc_en  output  1  PC drives bus.
- pc_inc  output  1  PC increments at next posedge.
- pc_load  output  1  PC loads bus at next posedge.
- ar_load  output  1  address register loads bus at next posedge.
- mem_en  output  1  memory drives bus.
- ir  output  WIDTH  instruction register.
- exec  output  1  execute phase active.
- tstate  output  $clog2(MAX_T)  current T-state.
- halted  output  1  sequencer stopped.

Behaviour:
- Reset: reset_bar=0 asynchronously sets state=FETCH_ADDR, ir=0, tstate=0, halted=0.
  - While reset_bar=0, every strobe output (pc_en, pc_inc, pc_load, ar_load, mem_en, exec) is forced 0.
  - A reset asserted mid-instruction abandons it; no strobe glitches after reset falls.
- Strobes are combinational from state and inputs. The PC and address register act on them at the following posedge.
- FETCH_ADDR (tstate=0):
  - Outputs: pc_en=1, ar_load=1.
  - halt=1 at posedge -> HALT.
  - Otherwise -> FETCH_DATA.
- FETCH_DATA (tstate=1):
  - Outputs: mem_en=1; pc_inc=mem_ready.
  - mem_ready=1 at posedge: ir<=bus, PC increments on the same edge, -> EXEC with tstate=2.
  - mem_ready=0: hold state, tstate stays 1, no timeout.
- EXEC (tstate 2..MAX_T-1):
  - Outputs: exec=1; pc_load=jump.
  - tstate increments each posedge.
  - exec_done=1 at posedge -> FETCH_ADDR, tstate=0.
  - If tstate==MAX_T-1 at a posedge -> FETCH_ADDR regardless of exec_done; no wrap past MAX_T-1.
  - jump and exec_done in the same cycle: both take effect; the next fetch uses the loaded address.
- HALT:
  - Outputs: halted=1, all strobes 0, tstate=0.
  - halt=0 at posedge -> FETCH_ADDR with halted=0.
  - halt is sampled only in FETCH_ADDR and HALT; raising it mid-instruction completes that instruction first.
- Invariants:
  - pc_en and mem_en are never both 1.
  - pc_inc and pc_load are never both 1.
  - ir changes only on a FETCH_DATA posedge with mem_ready=1, or on reset.
- Inputs mem_ready, exec_done and jump are ignored outside the states that use them.

Test Plan:
- Reset then release, bus=0x1234, mem_ready=1, exec_done=1 in first EXEC cycle:
  - FETCH_ADDR: pc_en=1, ar_load=1, tstate=0.
  - FETCH_DATA: mem_en=1, pc_inc=1, tstate=1.
  - EXEC: ir=0x1234, exec=1, tstate=2.
  - Then back to tstate=0.
- mem_ready held 0 for 5 cycles in FETCH_DATA, then bus=0xBEEF with mem_ready=1:
  - tstate stays 1, pc_inc=0, ir unchanged for 5 cycles.
  - ir=0xBEEF after the edge, pc_inc pulses exactly one cycle.
- exec_done never asserted, MAX_T=8:
  - tstate goes 2,3,4,5,6,7 then 0.
  - exec=1 for exactly 6 cycles.
- jump=1 with bus=0x0800 at tstate=3, exec_done=1 at tstate=4:
  - pc_load=1 only during tstate=3.
  - pc_inc never coincides with pc_load.
- halt raised at tstate=4:
  - Instruction completes, FETCH_ADDR entered once, then halted=1 with all strobes 0.
  - halt=0 -> next cycle tstate=0, pc_en=1.
- reset_bar pulsed low at tstate=5:
  - All strobes 0 immediately, ir=0.
  - After release, fetch restarts at tstate=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives PC / address-register / memory strobes,
// captures the instruction word and times the execute phase in T-states.
module fetch_sequencer #(
   parameter int  WIDTH = 16,
   parameter int  MAX_T = 8,
   localparam int TW    = $clog2(MAX_T)
) (
   input  logic             clk,
   input  logic             reset_bar,
   input  logic [WIDTH-1:0] bus,
   input  logic             mem_ready,
   input  logic             exec_done,
   input  logic             jump,
   input  logic             halt,
   output logic             pc_en,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             ar_load,
   output logic             mem_en,
   output logic [WIDTH-1:0] ir,
   output logic             exec,
   output logic [TW-1:0]    tstate,
   output logic             halted
);

   typedef enum logic [1:0] {
      FETCH_ADDR = 2'd0,
      FETCH_DATA = 2'd1,
      EXEC       = 2'd2,
      HALT       = 2'd3
   } state_t;

   localparam logic [TW-1:0] T_ADDR = TW'(0);
   localparam logic [TW-1:0] T_DATA = TW'(1);
   localparam logic [TW-1:0] T_EXEC = TW'(2);
   localparam logic [TW-1:0] T_LAST = TW'(MAX_T - 1);

   state_t           state_q, state_d;
   logic [TW-1:0]    tstate_q, tstate_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic             halted_q, halted_d;

   // Strobes are gated by reset_bar so nothing reaches the datapath while reset is held.
   always_comb begin
      pc_en   = 1'b0;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      ar_load = 1'b0;
      mem_en  = 1'b0;
      exec    = 1'b0;
      if (reset_bar) begin
         case (state_q)
            FETCH_ADDR: begin
               pc_en   = 1'b1;
               ar_load = 1'b1;
            end
            FETCH_DATA: begin
               mem_en = 1'b1;
               pc_inc = mem_ready;
            end
            EXEC: begin
               exec    = 1'b1;
               pc_load = jump;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      tstate_d = tstate_q;
      ir_d     = ir_q;
      halted_d = halted_q;
      case (state_q)
         FETCH_ADDR: begin
            if (halt) begin
               state_d  = HALT;
               tstate_d = T_ADDR;
               halted_d = 1'b1;
            end else begin
               state_d  = FETCH_DATA;
               tstate_d = T_DATA;
            end
         end
         FETCH_DATA: begin
            if (mem_ready) begin
               state_d  = EXEC;
               tstate_d = T_EXEC;
               ir_d     = bus;
            end
         end
         EXEC: begin
            // The last T-state ends the instruction even without exec_done.
            if (exec_done || (tstate_q == T_LAST)) begin
               state_d  = FETCH_ADDR;
               tstate_d = T_ADDR;
            end else begin
               tstate_d = tstate_q + TW'(1);
            end
         end
         HALT: begin
            tstate_d = T_ADDR;
            if (!halt) begin
               state_d  = FETCH_ADDR;
               halted_d = 1'b0;
            end
         end
         default: begin
            state_d  = FETCH_ADDR;
            tstate_d = T_ADDR;
            halted_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         state_q  <= FETCH_ADDR;
         tstate_q <= T_ADDR;
         ir_q     <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tstate_q <= tstate_d;
         ir_q     <= ir_d;
         halted_q <= halted_d;
      end
   end

   assign ir     = ir_q;
   assign tstate = tstate_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-computed strobe, ir and tstate
// expectations across fetch, stall, timeout, jump, halt and reset scenarios.
module tb_fetch_sequencer;

   localparam int WIDTH = 16;
   localparam int MAX_T = 8;
   localparam int TW    = $clog2(MAX_T);

   logic             clk;
   logic             reset_bar;
   logic [WIDTH-1:0] bus;
   logic             mem_ready, exec_done, jump, halt;
   logic             pc_en, pc_inc, pc_load, ar_load, mem_en, exec, halted;
   logic [WIDTH-1:0] ir;
   logic [TW-1:0]    tstate;
   logic [6:0]       strb;

   int n_vec = 0;
   int n_bad = 0;
   int cnt;

   // {pc_en, pc_inc, pc_load, ar_load, mem_en, exec, halted}
   localparam logic [6:0] S_NONE  = 7'b000_0000;
   localparam logic [6:0] S_FADDR = 7'b100_1000;
   localparam logic [6:0] S_FDATA = 7'b010_0100;
   localparam logic [6:0] S_FWAIT = 7'b000_0100;
   localparam logic [6:0] S_EXEC  = 7'b000_0010;
   localparam logic [6:0] S_JUMP  = 7'b001_0010;
   localparam logic [6:0] S_HALT  = 7'b000_0001;

   assign strb = {pc_en, pc_inc, pc_load, ar_load, mem_en, exec, halted};

   fetch_sequencer #(.WIDTH(WIDTH), .MAX_T(MAX_T)) dut (
      .clk       (clk),
      .reset_bar (reset_bar),
      .bus       (bus),
      .mem_ready (mem_ready),
      .exec_done (exec_done),
      .jump      (jump),
      .halt      (halt),
      .pc_en     (pc_en),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .ar_load   (ar_load),
      .mem_en    (mem_en),
      .ir        (ir),
      .exec      (exec),
      .tstate    (tstate),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Invariants checked mid-cycle, well away from input changes.
   always @(negedge clk) begin
      if (reset_bar) begin
         chk("inv_pcen_memen", 32'(pc_en & mem_en), 32'd0);
         chk("inv_inc_load", 32'(pc_inc & pc_load), 32'd0);
      end
   end

   initial begin
      reset_bar = 1'b0;
      bus = '0; mem_ready = 1'b0; exec_done = 1'b0; jump = 1'b0; halt = 1'b0;
      #1;
      chk("rst_strb", 32'(strb), 32'(S_NONE));
      chk("rst_ir", 32'(ir), 32'h0);
      chk("rst_tstate", 32'(tstate), 32'd0);

      // Basic fetch with exec_done in first EXEC cycle
      @(posedge clk); #2;
      reset_bar = 1'b1; bus = 16'h1234; mem_ready = 1'b1; exec_done = 1'b1;
      #1;
      chk("t1_faddr_strb", 32'(strb), 32'(S_FADDR));
      chk("t1_faddr_t", 32'(tstate), 32'd0);
      tick();
      chk("t1_fdata_strb", 32'(strb), 32'(S_FDATA));
      chk("t1_fdata_t", 32'(tstate), 32'd1);
      tick();
      chk("t1_exec_strb", 32'(strb), 32'(S_EXEC));
      chk("t1_exec_ir", 32'(ir), 32'h1234);
      chk("t1_exec_t", 32'(tstate), 32'd2);
      tick();
      chk("t1_back_t", 32'(tstate), 32'd0);
      chk("t1_back_strb", 32'(strb), 32'(S_FADDR));

      // Memory stall for 5 cycles
      mem_ready = 1'b0; exec_done = 1'b0;
      tick();
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_wait_t", 32'(tstate), 32'd1);
         chk("t2_wait_strb", 32'(strb), 32'(S_FWAIT));
         chk("t2_wait_ir", 32'(ir), 32'h1234);
         tick();
      end
      bus = 16'hBEEF; mem_ready = 1'b1;
      #1;
      if (pc_inc) cnt++;
      chk("t2_ready_strb", 32'(strb), 32'(S_FDATA));
      tick();
      mem_ready = 1'b0;
      #1;
      if (pc_inc) cnt++;
      chk("t2_ir", 32'(ir), 32'hBEEF);
      chk("t2_inc_pulses", 32'(cnt), 32'd1);

      // No exec_done: T-state timeout at MAX_T-1
      cnt = 0;
      for (int t = 2; t < MAX_T; t++) begin
         chk("t3_t", 32'(tstate), 32'(t));
         chk("t3_strb", 32'(strb), 32'(S_EXEC));
         if (exec) cnt++;
         tick();
      end
      chk("t3_wrap_t", 32'(tstate), 32'd0);
      chk("t3_wrap_strb", 32'(strb), 32'(S_FADDR));
      chk("t3_exec_cycles", 32'(cnt), 32'd6);

      // jump ignored outside EXEC
      jump = 1'b1;
      #1;
      chk("t4_jump_ign", 32'(strb), 32'(S_FADDR));
      jump = 1'b0;
      tick();
      bus = 16'hA5A5; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1;
      chk("t4_ir", 32'(ir), 32'hA5A5);
      chk("t4_t2_strb", 32'(strb), 32'(S_EXEC));
      tick();
      jump = 1'b1; bus = 16'h0800;
      #1;
      chk("t4_t3_t", 32'(tstate), 32'd3);
      chk("t4_t3_strb", 32'(strb), 32'(S_JUMP));
      tick();
      jump = 1'b0; exec_done = 1'b1;
      #1;
      chk("t4_t4_t", 32'(tstate), 32'd4);
      chk("t4_t4_strb", 32'(strb), 32'(S_EXEC));
      tick();
      exec_done = 1'b0;
      #1;
      chk("t4_done_t", 32'(tstate), 32'd0);
      chk("t4_ir_keep", 32'(ir), 32'hA5A5);

      // halt raised mid-instruction
      tick();
      bus = 16'h1111; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      halt = 1'b1;
      #1;
      chk("t5_t4_t", 32'(tstate), 32'd4);
      chk("t5_t4_strb", 32'(strb), 32'(S_EXEC));
      tick();
      chk("t5_t5_strb", 32'(strb), 32'(S_EXEC));
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      #1;
      chk("t5_faddr_strb", 32'(strb), 32'(S_FADDR));
      tick();
      chk("t5_halt_strb", 32'(strb), 32'(S_HALT));
      chk("t5_halt_t", 32'(tstate), 32'd0);
      tick();
      chk("t5_halt2_strb", 32'(strb), 32'(S_HALT));
      halt = 1'b0;
      tick();
      chk("t5_resume_t", 32'(tstate), 32'd0);
      chk("t5_resume_strb", 32'(strb), 32'(S_FADDR));

      // Reset mid-execute
      tick();
      bus = 16'h2222; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      tick();
      chk("t6_t5_t", 32'(tstate), 32'd5);
      chk("t6_ir_pre", 32'(ir), 32'h2222);
      reset_bar = 1'b0;
      #1;
      chk("t6_rst_strb", 32'(strb), 32'(S_NONE));
      chk("t6_rst_ir", 32'(ir), 32'h0);
      chk("t6_rst_t", 32'(tstate), 32'd0);
      tick();
      chk("t6_rst_hold", 32'(strb), 32'(S_NONE));
      reset_bar = 1'b1;
      #1;
      chk("t6_rel_t", 32'(tstate), 32'd0);
      chk("t6_rel_strb", 32'(strb), 32'(S_FADDR));
      tick();
      chk("t6_fdata_t", 32'(tstate), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
